// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the Execute-stage integer divider: FSM state
// encoding, the number of restoring steps per divide, and the MIPS
// opcode/funct values that select DIV and DIVU in the decoder.
// -----------------------------------------------------------------------------
package div_unit_pkg;

   // Divider FSM states (2-bit encoding).
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // One restoring step per quotient bit.
   localparam int DIV_CYCLES = 32;

   // MIPS encodings for the instructions this unit serves.
   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
// Operands are sampled once when the divide is accepted; the unit then runs
// one quotient bit per cycle on magnitudes and applies the sign fix-ups as
// the last step retires.
//
// Ports:
//   clk         pipeline clock
//   resetn      asynchronous active-low reset
//   startE      E-stage instruction is DIV/DIVU (held while E is stalled)
//   signedE     1 = DIV (signed), 0 = DIVU
//   aE, bE      dividend / divisor after forwarding
//   annulE      exception flush; cancels any divide in progress
//   stall_divE  to hazard unit, high while a divide is pending
//   readyE      one-cycle pulse, resultE valid this cycle
//   resultE     {HI = remainder, LO = quotient}, held until the next divide
// -----------------------------------------------------------------------------
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_CYCLES
)
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 startE,
   input  logic                 signedE,
   input  logic [WIDTH-1:0]     aE,
   input  logic [WIDTH-1:0]     bE,
   input  logic                 annulE,
   output logic                 stall_divE,
   output logic                 readyE,
   output logic [2*WIDTH-1:0]   resultE
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

   div_state_t          state_r;
   div_state_t          state_nxt_s;
   logic [CW-1:0]       cnt_r;
   logic [2*WIDTH-1:0]  acc_r;      // {partial remainder, dividend -> quotient}
   logic [WIDTH-1:0]    dvsr_r;
   logic                qneg_r;
   logic                rneg_r;
   logic [2*WIDTH-1:0]  result_r;
   logic                ready_r;

   logic                a_neg_s;
   logic                b_neg_s;
   logic [WIDTH-1:0]    a_mag_s;
   logic [WIDTH-1:0]    b_mag_s;
   logic [WIDTH:0]      shr_s;
   logic                ge_s;
   logic [WIDTH-1:0]    sub_s;
   logic [2*WIDTH-1:0]  acc_nxt_s;
   logic [WIDTH-1:0]    q_s;
   logic [WIDTH-1:0]    r_s;
   logic [WIDTH-1:0]    q_fix_s;
   logic [WIDTH-1:0]    r_fix_s;

   // Operand magnitudes: only DIV treats the MSB as a sign.
   assign a_neg_s = signedE & aE[WIDTH-1];
   assign b_neg_s = signedE & bE[WIDTH-1];
   assign a_mag_s = a_neg_s ? (~aE + ONE) : aE;
   assign b_mag_s = b_neg_s ? (~bE + ONE) : bE;

   // Restoring step. The shifted remainder needs WIDTH+1 bits because the
   // remainder can be as large as divisor-1 before doubling. When the trial
   // subtraction succeeds the difference is below the divisor, so the low
   // WIDTH bits of the difference are exact.
   assign shr_s = acc_r[2*WIDTH-1:WIDTH-1];
   assign ge_s  = (shr_s >= {1'b0, dvsr_r});
   assign sub_s = shr_s[WIDTH-1:0] - dvsr_r;
   assign acc_nxt_s = ge_s ? {sub_s,              acc_r[WIDTH-2:0], 1'b1}
                           : {shr_s[WIDTH-1:0],   acc_r[WIDTH-2:0], 1'b0};

   // Sign fix-up applied to the result of the final step.
   assign q_s     = acc_nxt_s[WIDTH-1:0];
   assign r_s     = acc_nxt_s[2*WIDTH-1:WIDTH];
   assign q_fix_s = qneg_r ? (~q_s + ONE) : q_s;
   assign r_fix_s = rneg_r ? (~r_s + ONE) : r_s;

   // Hazard-unit stall: depends only on state, startE and annulE.
   assign stall_divE = ~annulE & (((state_r == DIV_IDLE) & startE) | (state_r == DIV_BUSY));

   assign readyE  = ready_r;
   assign resultE = result_r;

   // Next-state logic; a flush always returns the FSM to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      if (annulE) begin
         state_nxt_s = DIV_IDLE;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (startE) begin
                  state_nxt_s = DIV_BUSY;
               end else begin
                  state_nxt_s = DIV_IDLE;
               end
            end
            DIV_BUSY: begin
               if (cnt_r == CNT_LAST) begin
                  state_nxt_s = DIV_DONE;
               end else begin
                  state_nxt_s = DIV_BUSY;
               end
            end
            DIV_DONE: state_nxt_s = DIV_IDLE;
            default:  state_nxt_s = DIV_IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath: operand capture, iteration, and result commit. The result
   // and ready pulse are registered as the last step retires, so both are
   // visible during the DONE cycle; an annul on that last step commits nothing.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r    <= {CW{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
         dvsr_r   <= ZERO;
         qneg_r   <= 1'b0;
         rneg_r   <= 1'b0;
         result_r <= {(2*WIDTH){1'b0}};
         ready_r  <= 1'b0;
      end else begin
         ready_r <= 1'b0;
         case (state_r)
            DIV_IDLE: begin
               if (startE & ~annulE) begin
                  acc_r  <= {ZERO, a_mag_s};
                  dvsr_r <= b_mag_s;
                  qneg_r <= signedE & (aE[WIDTH-1] ^ bE[WIDTH-1]);
                  rneg_r <= a_neg_s;
                  cnt_r  <= {CW{1'b0}};
               end
            end
            DIV_BUSY: begin
               if (!annulE) begin
                  acc_r <= acc_nxt_s;
                  cnt_r <= cnt_r + CNT_ONE;
                  if (cnt_r == CNT_LAST) begin
                     result_r <= {r_fix_s, q_fix_s};
                     ready_r  <= 1'b1;
                  end
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

endmodule : div_unit

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed cases, annul, reset and
// randomized divides compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic        clk;
   logic        resetn;
   logic        startE;
   logic        signedE;
   logic [31:0] aE;
   logic [31:0] bE;
   logic        annulE;
   logic        stall_divE;
   logic        readyE;
   logic [63:0] resultE;

   int n_vec;
   int n_err;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .startE     (startE),
      .signedE    (signedE),
      .aE         (aE),
      .bE         (bE),
      .annulE     (annulE),
      .stall_divE (stall_divE),
      .readyE     (readyE),
      .resultE    (resultE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: MIPS quotient truncates toward zero, remainder takes the
   // dividend's sign; division by zero yields all-ones magnitude quotient and
   // |a| remainder before sign fixes.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      longint      sa;
      longint      sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = (s && a[31]) ? (32'd0 - a) : a;
         if (s && a[31]) begin
            q = 32'd0 - q;
            r = 32'd0 - r;
         end
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete divide: checks idle state, 33 stall cycles, ready on
   // cycle 33, and the result. Operands are scrambled after cycle 0.
   task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
      int stalls;
      int rdy_cyc;
      @(posedge clk); #1;
      chk({tag, "_idle_ready"}, 64'(readyE), 64'd0);
      chk({tag, "_idle_stall"}, 64'(stall_divE), 64'd0);
      startE = 1'b1; signedE = s; aE = a; bE = b;
      stalls = 0;
      rdy_cyc = -1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (stall_divE) stalls++;
         if (readyE) begin
            rdy_cyc = c;
            break;
         end
         @(posedge clk); #1;
         aE = $urandom;
         bE = $urandom;
      end
      chk({tag, "_ready_cycle"}, 64'(rdy_cyc), 64'd33);
      chk({tag, "_stall_cycles"}, 64'(stalls), 64'd33);
      chk({tag, "_result"}, resultE, exp);
      startE = 1'b0;
   endtask

   initial begin
      logic [63:0] prev;
      logic        seen;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      n_vec = 0;
      n_err = 0;
      resetn = 1'b0; startE = 1'b0; signedE = 1'b0;
      aE = 32'd0; bE = 32'd0; annulE = 1'b0;
      #12;
      chk("reset_ready", 64'(readyE), 64'd0);
      chk("reset_stall", 64'(stall_divE), 64'd0);
      chk("reset_result", resultE, 64'd0);
      @(negedge clk); resetn = 1'b1;

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC});
      run_div("div_by_zero", 1'b1, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'h0000_0001});
      run_div("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});

      // Annul mid-BUSY.
      prev = resultE;
      @(posedge clk); #1;
      startE = 1'b1; signedE = 1'b0; aE = 32'd1000; bE = 32'd3;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      annulE = 1'b1;
      #1;
      chk("annul_stall_drop", 64'(stall_divE), 64'd0);
      @(posedge clk); #1;
      annulE = 1'b0; startE = 1'b0;
      #1;
      chk("annul_idle_next", 64'(stall_divE), 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (readyE) seen = 1'b1;
      end
      chk("annul_no_ready", 64'(seen), 64'd0);
      chk("annul_result_hold", resultE, prev);

      // Annul overrides a start in IDLE.
      @(posedge clk); #1;
      startE = 1'b1; annulE = 1'b1; aE = 32'd50; bE = 32'd5;
      #1;
      chk("annul_vs_start_stall", 64'(stall_divE), 64'd0);
      @(posedge clk); #1;
      startE = 1'b0; annulE = 1'b0;
      #1;
      chk("annul_vs_start_idle", 64'(stall_divE), 64'd0);

      run_div("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

      // Back-to-back: second start lands in the IDLE cycle right after DONE.
      run_div("b2b_divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
      run_div("b2b_div_20_m6", 1'b1, 32'd20, 32'hFFFF_FFFA, {32'd2, 32'hFFFF_FFFD});

      // Randomized divides.
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 15));
            1:       b = 32'($urandom_range(0, 65535));
            default: b = $urandom;
         endcase
         if (i == 5) a = 32'h8000_0000;
         run_div("random", s, a, b, model(s, a, b));
      end

      // Asynchronous reset mid-BUSY.
      run_div("pre_reset", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15});
      @(posedge clk); #1;
      startE = 1'b1; signedE = 1'b1; aE = 32'd12345; bE = 32'd17;
      repeat (15) @(posedge clk);
      #3;
      resetn = 1'b0; startE = 1'b0;
      #1;
      chk("rst_mid_ready", 64'(readyE), 64'd0);
      chk("rst_mid_stall", 64'(stall_divE), 64'd0);
      chk("rst_mid_result", resultE, 64'd0);
      #10;
      @(negedge clk); #2;
      resetn = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (readyE || stall_divE) seen = 1'b1;
      end
      chk("rst_release_quiet", 64'(seen), 64'd0);
      run_div("post_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_div_unit
